// File: rtl/sysid_info_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysid_info_pkg
// Description : Shared register offsets, CONTROL bit positions and limits for
//               the system-ID / uptime information block.
// Revision    : 1.0 - initial release
// ============================================================================
package sysid_info_pkg;

    // Largest supported number of read-only user info words
    localparam int c_max_user_words = 8;

    // Word offsets within the register window
    localparam logic [3:0] c_addr_system_id = 4'd0;
    localparam logic [3:0] c_addr_timestamp = 4'd1;
    localparam logic [3:0] c_addr_uptime_lo = 4'd2;
    localparam logic [3:0] c_addr_uptime_hi = 4'd3;
    localparam logic [3:0] c_addr_scratch   = 4'd4;
    localparam logic [3:0] c_addr_control   = 4'd5;
    localparam logic [3:0] c_addr_info      = 4'd6;
    localparam logic [3:0] c_addr_user_base = 4'd8;

    // CONTROL register bit positions
    localparam int c_ctrl_clear_bit  = 0;
    localparam int c_ctrl_freeze_bit = 1;

endpackage
`default_nettype wire

// File: rtl/sysid_uptime_counter.sv
`default_nettype none
// ============================================================================
// Module      : sysid_uptime_counter
// Description : 64-bit free-running uptime counter with synchronous clear,
//               freeze control and a high-word shadow for coherent reads.
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_uptime_counter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,       // zero the counter at this edge
    input  logic        freeze_wr,   // load the FREEZE bit at this edge
    input  logic        freeze_val,
    input  logic        snap,        // capture the high word into the shadow
    output logic [63:0] count,
    output logic [31:0] shadow_hi,
    output logic        freeze
);

    logic [63:0] r_count;
    logic [31:0] r_shadow_hi;
    logic        r_freeze;

    // Counter: clear wins over both freeze and increment; wraps naturally
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (!r_freeze) begin
            r_count <= r_count + 64'd1;
        end
    end

    // FREEZE bit takes effect from the edge after it is written
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_freeze <= 1'b0;
        end else if (freeze_wr) begin
            r_freeze <= freeze_val;
        end
    end

    // Shadow the high word at the moment the low word is read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow_hi <= '0;
        end else if (snap) begin
            r_shadow_hi <= r_count[63:32];
        end
    end

    assign count     = r_count;
    assign shadow_hi = r_shadow_hi;
    assign freeze    = r_freeze;

endmodule
`default_nettype wire

// File: rtl/sysid_info_block.sv
`default_nettype none
// ============================================================================
// Module      : sysid_info_block
// Description : Avalon-MM slave exposing system ID, build timestamp, uptime
//               counter, scratch/control registers and read-only user words.
//               Zero wait states; fixed, parameterised read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_info_block
    import sysid_info_pkg::*;
#(
    parameter logic [31:0]                  SYSTEM_ID      = 32'h0000_0000,
    parameter logic [31:0]                  TIMESTAMP      = 32'h0000_0000,
    parameter int                           NUM_USER_WORDS = 4,
    parameter logic [32*NUM_USER_WORDS-1:0] USER_WORDS     = '0,
    parameter int                           READ_LATENCY   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        waitrequest
);

    // Elaboration-time parameter range checks
    if (NUM_USER_WORDS < 1 || NUM_USER_WORDS > c_max_user_words) begin : g_bad_num_user_words
        $error("sysid_info_block: NUM_USER_WORDS out of range 1..8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_read_latency
        $error("sysid_info_block: READ_LATENCY out of range 1..3");
    end

    logic        w_rd_acc;
    logic        w_ctrl_wr;
    logic        w_scratch_wr;
    logic [63:0] w_count;
    logic [31:0] w_shadow_hi;
    logic        w_freeze;
    logic [31:0] w_scratch;
    logic [31:0] w_rd_data;
    logic [31:0] w_user [c_max_user_words];
    logic [7:0]  r_scratch_lane [4];
    logic        r_vld  [READ_LATENCY];
    logic [31:0] r_data [READ_LATENCY];

    // A simultaneous write swallows the read
    assign w_rd_acc     = read & ~write;
    assign w_ctrl_wr    = write && (address == c_addr_control) && byteenable[0];
    assign w_scratch_wr = write && (address == c_addr_scratch);
    assign waitrequest  = 1'b0;

    sysid_uptime_counter u_uptime (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (w_ctrl_wr & writedata[c_ctrl_clear_bit]),
        .freeze_wr  (w_ctrl_wr),
        .freeze_val (writedata[c_ctrl_freeze_bit]),
        .snap       (w_rd_acc && (address == c_addr_uptime_lo)),
        .count      (w_count),
        .shadow_hi  (w_shadow_hi),
        .freeze     (w_freeze)
    );

    // User words padded with zeros up to the maximum slot count
    for (genvar k = 0; k < c_max_user_words; k++) begin : g_user
        if (k < NUM_USER_WORDS) begin : g_used
            assign w_user[k] = USER_WORDS[32*k +: 32];
        end else begin : g_unused
            assign w_user[k] = 32'd0;
        end
    end

    // SCRATCH: one register per byte lane, each gated by its byteenable
    for (genvar b = 0; b < 4; b++) begin : g_lane
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_scratch_lane[b] <= '0;
            end else if (w_scratch_wr && byteenable[b]) begin
                r_scratch_lane[b] <= writedata[8*b +: 8];
            end
        end
    end

    assign w_scratch = {r_scratch_lane[3], r_scratch_lane[2], r_scratch_lane[1], r_scratch_lane[0]};

    // Register map decode using pre-edge state
    always_comb begin
        w_rd_data = 32'd0;
        case (address)
            c_addr_system_id: w_rd_data = SYSTEM_ID;
            c_addr_timestamp: w_rd_data = TIMESTAMP;
            c_addr_uptime_lo: w_rd_data = w_count[31:0];
            c_addr_uptime_hi: w_rd_data = w_shadow_hi;
            c_addr_scratch:   w_rd_data = w_scratch;
            c_addr_control:   w_rd_data = {30'd0, w_freeze, 1'b0};
            c_addr_info:      w_rd_data = {24'd0, 8'(NUM_USER_WORDS)};
            default: begin
                if (address[3]) begin
                    w_rd_data = w_user[address[2:0]];
                end
            end
        endcase
    end

    // Read pipeline: data is zeroed in any slot that carries no valid read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_vld[i]  <= 1'b0;
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= w_rd_acc;
            r_data[0] <= w_rd_acc ? w_rd_data : 32'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign readdatavalid = r_vld[READ_LATENCY-1];
    assign readdata      = r_data[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_sysid_info_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysid_info_block
// Description : Scoreboard bench for sysid_info_block with a behavioural
//               register/counter model and randomized bus traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_info_block;

    localparam logic [31:0] SID = 32'h1234_5678;
    localparam logic [31:0] TS  = 32'h6500_0000;
    localparam int          NUW = 2;
    localparam logic [31:0] UW0 = 32'hCAFE_0001;
    localparam logic [31:0] UW1 = 32'h0BAD_F00D;
    localparam int          LAT = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    sysid_info_block #(
        .SYSTEM_ID      (SID),
        .TIMESTAMP      (TS),
        .NUM_USER_WORDS (NUW),
        .USER_WORDS     ({UW1, UW0}),
        .READ_LATENCY   (LAT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    longint      edge_cnt = 0;
    logic [63:0] m_cnt = '0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_scratch = '0;
    logic        m_freeze = 1'b0;
    bit          m_load = 1'b0;
    logic [63:0] m_load_val = '0;

    typedef struct {
        logic [31:0] data;
        longint      due;
        logic [3:0]  addr;
    } exp_t;
    exp_t q[$];

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'd0: return SID;
            4'd1: return TS;
            4'd2: return m_cnt[31:0];
            4'd3: return m_shadow;
            4'd4: return m_scratch;
            4'd5: return {30'd0, m_freeze, 1'b0};
            4'd6: return 32'(NUW);
            4'd8: return UW0;
            4'd9: return UW1;
            default: return 32'd0;
        endcase
    endfunction

    // Model: register-level rules applied at every clock edge
    always @(posedge clock) begin
        edge_cnt <= edge_cnt + 1;
        if (!reset_n) begin
            m_cnt     <= '0;
            m_shadow  <= '0;
            m_scratch <= '0;
            m_freeze  <= 1'b0;
        end else begin
            if (read && !write && address == 4'd2) m_shadow <= m_cnt[63:32];
            if (write && address == 4'd4)
                for (int i = 0; i < 4; i++)
                    if (byteenable[i]) m_scratch[8*i +: 8] <= writedata[8*i +: 8];
            if (m_load) m_cnt <= m_load_val;
            else if (write && address == 4'd5 && byteenable[0] && writedata[0]) m_cnt <= '0;
            else if (!m_freeze) m_cnt <= m_cnt + 64'd1;
            if (write && address == 4'd5 && byteenable[0]) m_freeze <= writedata[1];
        end
    end

    // Monitor: compare every presented read against the scoreboard
    always @(negedge clock) begin
        if (!reset_n) begin
            checks++;
            if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
                failures++;
                $display("FAIL reset_outputs: valid=%b data=%h required valid=0 data=0", readdatavalid, readdata);
            end
        end else begin
            checks++;
            if (waitrequest !== 1'b0) begin
                failures++;
                $display("FAIL waitrequest: got %b required 0", waitrequest);
            end
            if (readdatavalid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_valid: data=%h with no read outstanding", readdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (readdata !== e.data || edge_cnt != e.due) begin
                        failures++;
                        $display("FAIL read_addr%0d: data=%h at edge %0d required data=%h at edge %0d",
                                 e.addr, readdata, edge_cnt, e.data, e.due);
                    end
                end
            end else if (readdata !== 32'd0) begin
                checks++;
                failures++;
                $display("FAIL idle_readdata: got %h required 0", readdata);
            end
            if (q.size() != 0 && q[0].due < edge_cnt) begin
                checks++;
                failures++;
                $display("FAIL missing_valid: addr %0d due edge %0d, now %0d, expected data %h",
                         q[0].addr, q[0].due, edge_cnt, q[0].data);
                void'(q.pop_front());
            end
        end
    end

    // Drive one bus cycle starting at a falling edge; log the expected read
    task automatic bus(input bit rd, input bit wr, input logic [3:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        if (rd && !wr) begin
            e.data = model_read(a);
            e.due  = edge_cnt + LAT;
            e.addr = a;
            q.push_back(e);
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        bus(1'b1, 1'b0, a, 32'd0, 4'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        bus(1'b0, 1'b1, a, d, be);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Constant words, info, user slots, unmapped slots
        rd(4'd0); rd(4'd1); rd(4'd6); rd(4'd8);
        idle(1);
        rd(4'd10); rd(4'd7); rd(4'd9); rd(4'd15); rd(4'd5); rd(4'd2);
        idle(3);

        // Scratch byte lanes
        wr(4'd4, 32'hFFFF_FFFF, 4'b1111);
        wr(4'd4, 32'h0000_00AA, 4'b0001);
        rd(4'd4);
        wr(4'd4, 32'h5500_0000, 4'b1000);
        rd(4'd4);
        wr(4'd7, 32'hDEAD_BEEF, 4'b1111);
        rd(4'd7);
        idle(3);

        // Coherent LO/HI across a low-word carry
        force dut.u_uptime.r_count = 64'h0000_0000_FFFF_FFFF;
        m_load_val = 64'h0000_0000_FFFF_FFFF;
        m_load = 1'b1;
        @(negedge clock);
        rd(4'd2);
        release dut.u_uptime.r_count;
        m_load = 1'b0;
        idle(2);
        rd(4'd3);
        rd(4'd2);
        rd(4'd3);
        idle(3);

        // Freeze holds, clear wins over freeze
        wr(4'd5, 32'h0000_0002, 4'b1111);
        rd(4'd2);
        idle(10);
        rd(4'd2);
        wr(4'd5, 32'h0000_0003, 4'b1111);
        rd(4'd2); rd(4'd3); rd(4'd5);
        idle(5);
        rd(4'd2);
        wr(4'd5, 32'hFFFF_FFFC, 4'b1111);
        rd(4'd5);
        idle(3);
        rd(4'd2);

        // Read and write together: write lands, read is dropped
        bus(1'b1, 1'b1, 4'd4, 32'h1357_9BDF, 4'b1111);
        rd(4'd4);
        idle(4);

        // Reset in the middle of an outstanding read
        rd(4'd0);
        read = 1'b0;
        #2;
        reset_n = 1'b0;
        q.delete();
        repeat (2) @(negedge clock);
        #2;
        reset_n = 1'b1;
        @(negedge clock);
        idle(4);
        rd(4'd2); rd(4'd4); rd(4'd5);
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [3:0]  a;
            logic [31:0] d;
            r = int'($urandom_range(0, 99));
            a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 5));
            d = $urandom;
            if (a == 4'd5) d[0] = ($urandom_range(0, 7) == 0);
            if (r < 55)      bus(1'b1, 1'b0, a, 32'd0, 4'($urandom));
            else if (r < 80) bus(1'b0, 1'b1, a, d, 4'($urandom));
            else if (r < 85) bus(1'b1, 1'b1, a, d, 4'($urandom));
            else             idle(1);
        end
        idle(LAT + 3);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d reads outstanding, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
